encoder4_2_db: RTL
==================

ENCODER4_2_DB -- requirements
Module: encoder4_2_db

Interface
REQ-001 Parameter DB_CYCLES, default 16, number of consecutive stable cycles for press/release acceptance (legal range 2..65535).
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_n  input  4  active-low one-hot request lines (button/select lines), asynchronous to clk.
REQ-005 out_ready  input  1  consumer accepts code when high with valid.
REQ-006 code  output  2  encoded index of the low line (in_n[i]==0 -> code=i).
REQ-007 valid  output  1  code is valid; held until accepted.
REQ-008 err  output  1  one-cycle pulse: multi-line press rejected (only without the macro of REQ-026).
REQ-009 press_cnt  output  8  count of accepted codes, wraps 255->0.

Function
REQ-010 in_n SHALL pass a 2-flop synchronizer; all logic uses synchronized value s_n; no other combinational input-to-output path.
REQ-011 FSM states SHALL be IDLE, DEBOUNCE, HOLD, WAIT_RELEASE.
REQ-012 IDLE: s_n != 4'b1111 -> latch s_n into pat, clear counter, go DEBOUNCE; otherwise stay.
REQ-013 DEBOUNCE: s_n != pat -> clear counter, return IDLE (glitch rejected, no output activity).
REQ-014 DEBOUNCE: counter increments each cycle with s_n == pat; on reaching DB_CYCLES-1 the pattern is accepted.
REQ-015 Accepted pattern with exactly one zero bit -> code loaded, valid set, go HOLD.
REQ-016 valid SHALL rise exactly DB_CYCLES+3 rising edges after the first edge sampling the new stable in_n.
REQ-017 HOLD: valid and code SHALL stay constant regardless of in_n until a cycle with valid && out_ready.
REQ-018 On valid && out_ready: valid cleared next cycle, press_cnt incremented by 1 (mod 256), go WAIT_RELEASE.
REQ-019 WAIT_RELEASE: s_n must equal 4'b1111 for DB_CYCLES consecutive cycles before returning IDLE; any low bit clears the counter.
REQ-020 A held key SHALL produce exactly one valid transaction; no auto-repeat.
REQ-021 out_ready high in the same cycle valid first rises SHALL complete the handshake in that cycle (1-cycle valid).
REQ-022 code SHALL hold its last value when valid is low; verification checks code only while valid is high.

Reset
REQ-023 rst high at a clock edge SHALL force: state IDLE, synchronizer flops 4'b1111, pat 4'b1111, counter 0, code 2'b00, valid 0, err 0, press_cnt 0.
REQ-024 rst mid-DEBOUNCE or mid-HOLD SHALL drop a pending valid without incrementing press_cnt; a key still held after reset is re-debounced from IDLE.
REQ-025 rst has priority over every other condition in the same cycle.

Configuration
REQ-026 Macro MULTI_PRIORITY_EN defined: accepted pattern with two or more zero bits SHALL encode the lowest-index zero bit (in_n[0] highest priority) and proceed as REQ-015; err tied 0.
REQ-027 Macro MULTI_PRIORITY_EN undefined: accepted pattern with two or more zero bits SHALL pulse err for exactly one cycle, leave valid low, leave press_cnt unchanged, go WAIT_RELEASE.

Verification (DB_CYCLES=4 unless noted)
REQ-028 in_n=4'b1011 held 20 cycles, out_ready=1 -> valid high 1 cycle at edge 7 after first sample, code=2'b10, press_cnt=1, no second valid.
REQ-029 in_n=4'b1110 for 2 cycles then 4'b1111 -> no valid, no err, state returns IDLE, press_cnt=0.
REQ-030 in_n=4'b0111, out_ready=0 for 10 cycles then 1 -> valid held with code=2'b11 all 10 cycles, drops the cycle after ready, press_cnt=1.
REQ-031 in_n=4'b1100 held: macro undefined -> err one-cycle pulse, valid never high; macro defined -> valid with code=2'b00.
REQ-032 256 accepted presses (each released >=4 cycles) -> press_cnt wraps to 0; release shorter than 4 cycles between presses -> second press not reported.
REQ-033 rst asserted 1 cycle while valid high, out_ready=0 -> next cycle valid=0, press_cnt=0; key still held -> valid reasserts DB_CYCLES+3 edges after rst deasserts.

Source files
------------

// File: rtl/encoder4_2_db.sv
// encoder4_2_db: debounced 4-to-2 encoder with valid/ready handoff; ports clk, rst, in_n[3:0], out_ready -> code[1:0], valid, err, press_cnt[7:0]; MULTI_PRIORITY_EN selects priority encoding of multi-line presses instead of an err pulse
module encoder4_2_db #(
  parameter int unsigned DB_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] in_n,
  input  logic       out_ready,
  output logic [1:0] code,
  output logic       valid,
  output logic       err,
  output logic [7:0] press_cnt
);
  typedef enum logic [1:0] {IDLE, DEBOUNCE, HOLD, WAIT_RELEASE} state_t;
  localparam logic [15:0] LAST = 16'(DB_CYCLES - 1);
  state_t state_q, state_d;
  logic [3:0] meta_q, s_n_q, pat_q, pat_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0] code_q, code_d, low_idx;
  logic valid_q, valid_d, err_q, err_d;
  logic [7:0] press_q, press_d;
  assign low_idx = !pat_q[0] ? 2'd0 : !pat_q[1] ? 2'd1 : !pat_q[2] ? 2'd2 : 2'd3;
`ifndef MULTI_PRIORITY_EN
  logic [3:0] zero;
  logic multi;
  assign zero = ~pat_q;
  assign multi = |(zero & (zero - 4'd1));
`endif
  always_comb begin
    state_d = state_q;
    pat_d = pat_q;
    cnt_d = cnt_q;
    code_d = code_q;
    valid_d = valid_q;
    err_d = 1'b0;
    press_d = press_q;
    case (state_q)
      IDLE: if (s_n_q != 4'hf) begin
        pat_d = s_n_q;
        cnt_d = '0;
        state_d = DEBOUNCE;
      end
      DEBOUNCE: if (s_n_q != pat_q) begin
        cnt_d = '0;
        state_d = IDLE;
      end else if (cnt_q == LAST) begin
`ifdef MULTI_PRIORITY_EN
        code_d = low_idx;
        valid_d = 1'b1;
        state_d = HOLD;
`else
        if (multi) begin
          err_d = 1'b1;
          cnt_d = '0;
          state_d = WAIT_RELEASE;
        end else begin
          code_d = low_idx;
          valid_d = 1'b1;
          state_d = HOLD;
        end
`endif
      end else cnt_d = cnt_q + 16'd1;
      HOLD: if (out_ready) begin
        valid_d = 1'b0;
        press_d = press_q + 8'd1;
        cnt_d = '0;
        state_d = WAIT_RELEASE;
      end
      WAIT_RELEASE: if (s_n_q != 4'hf) cnt_d = '0;
        else if (cnt_q == LAST) begin
          cnt_d = '0;
          state_d = IDLE;
        end else cnt_d = cnt_q + 16'd1;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 4'hf;
      s_n_q <= 4'hf;
      state_q <= IDLE;
      pat_q <= 4'hf;
      cnt_q <= '0;
      code_q <= '0;
      valid_q <= 1'b0;
      err_q <= 1'b0;
      press_q <= '0;
    end else begin
      meta_q <= in_n;
      s_n_q <= meta_q;
      state_q <= state_d;
      pat_q <= pat_d;
      cnt_q <= cnt_d;
      code_q <= code_d;
      valid_q <= valid_d;
      err_q <= err_d;
      press_q <= press_d;
    end
  end
  assign code = code_q;
  assign valid = valid_q;
  assign err = err_q;
  assign press_cnt = press_q;
endmodule
